tcpbus_axi4_burst_master: RTL and testbench

- Parametrised successor to the fixed 128-bit tcpBus-to-AXI4 master in the DPI socket bridge.
- Converts one tcpBus command (start address, beat count, read/write) into a sequence of AXI4 INCR bursts.
- Bursts are split at MAX_BURST beats and, optionally, at 4 KB boundaries.
- Streams write data from tcpBus to the AXI W channel and read data from R to tcpBus, then returns a single aggregated response.

---
 rtl/tcpbus_axi4_burst_master.sv | 216 +++++++++++++++++++++
 tb/tb_tcpbus_axi4_burst_master.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcpbus_axi4_burst_master.sv
// tcpBus command to AXI4 INCR burst master: splits a beat count into MAX_BURST-sized bursts.
// Define TCPBUS_AXI4_4K_SPLIT_EN to also split bursts at 4 KB address boundaries.
module tcpbus_axi4_burst_master #(
    parameter int DATA_WIDTH = 128,
    parameter int MAX_BURST  = 256,
    parameter int SIZE_WIDTH = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tcpBus_cmd_valid,
    output logic                      tcpBus_cmd_ready,
    input  logic                      tcpBus_cmd_write,
    input  logic [31:0]               tcpBus_addr,
    input  logic [SIZE_WIDTH-1:0]     tcpBus_size,
    input  logic                      tcpBus_wdata_valid,
    output logic                      tcpBus_wdata_ready,
    input  logic [DATA_WIDTH-1:0]     tcpBus_wdata_payload_fragment,
    input  logic                      tcpBus_wdata_payload_last,
    output logic                      tcpBus_rdata_valid,
    input  logic                      tcpBus_rdata_ready,
    output logic [DATA_WIDTH-1:0]     tcpBus_rdata_payload_fragment,
    output logic                      tcpBus_rdata_payload_last,
    output logic                      tcpBus_rsp_valid,
    output logic [1:0]                tcpBus_rsp_payload,
    output logic                      masterAxi_aw_valid,
    input  logic                      masterAxi_aw_ready,
    output logic [31:0]               masterAxi_aw_addr,
    output logic [3:0]                masterAxi_aw_id,
    output logic [7:0]                masterAxi_aw_len,
    output logic [2:0]                masterAxi_aw_size,
    output logic [1:0]                masterAxi_aw_burst,
    output logic                      masterAxi_w_valid,
    input  logic                      masterAxi_w_ready,
    output logic [DATA_WIDTH-1:0]     masterAxi_w_data,
    output logic [DATA_WIDTH/8-1:0]   masterAxi_w_strb,
    output logic                      masterAxi_w_last,
    input  logic                      masterAxi_b_valid,
    output logic                      masterAxi_b_ready,
    input  logic [1:0]                masterAxi_b_resp,
    output logic                      masterAxi_ar_valid,
    input  logic                      masterAxi_ar_ready,
    output logic [31:0]               masterAxi_ar_addr,
    output logic [3:0]                masterAxi_ar_id,
    output logic [7:0]                masterAxi_ar_len,
    output logic [2:0]                masterAxi_ar_size,
    output logic [1:0]                masterAxi_ar_burst,
    input  logic                      masterAxi_r_valid,
    output logic                      masterAxi_r_ready,
    input  logic [DATA_WIDTH-1:0]     masterAxi_r_data,
    input  logic [1:0]                masterAxi_r_resp,
    input  logic                      masterAxi_r_last
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LOG_BYTES = $clog2(BYTES);
    localparam logic [2:0] AXI_SIZE = 3'(LOG_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RSP} state_t;

    state_t                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;
    logic [1:0]            resp_q, resp_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;

    logic [31:0] rem_ext;
    logic [8:0]  burst_beats;
    logic [31:0] addr_step;
    logic        final_burst;
    logic        unused_ok;

    // Write-data framing comes from the beat count, not the tcpBus last flag.
    assign unused_ok = tcpBus_wdata_payload_last;

`ifdef TCPBUS_AXI4_4K_SPLIT_EN
    logic [12:0] to_4k;
`endif

    always_comb begin
        rem_ext     = 32'(remaining_q);
        burst_beats = (rem_ext > 32'(MAX_BURST)) ? 9'(MAX_BURST) : rem_ext[8:0];
`ifdef TCPBUS_AXI4_4K_SPLIT_EN
        to_4k = 13'(13'h1000 - {1'b0, addr_q[11:0]}) >> LOG_BYTES;
        if (to_4k < {4'd0, burst_beats}) begin
            burst_beats = to_4k[8:0];
        end
`endif
        addr_step   = 32'(burst_beats) << LOG_BYTES;
        final_burst = (remaining_q == SIZE_WIDTH'(burst_beats));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            resp_q      <= 2'b00;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            resp_q      <= resp_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        resp_d      = resp_q;
        beat_cnt_d  = beat_cnt_q;

        tcpBus_cmd_ready              = 1'b0;
        tcpBus_wdata_ready            = 1'b0;
        tcpBus_rdata_valid            = 1'b0;
        tcpBus_rdata_payload_fragment = '0;
        tcpBus_rdata_payload_last     = 1'b0;
        tcpBus_rsp_valid              = 1'b0;
        tcpBus_rsp_payload            = 2'b00;
        masterAxi_aw_valid            = 1'b0;
        masterAxi_aw_addr             = '0;
        masterAxi_aw_id               = '0;
        masterAxi_aw_len              = '0;
        masterAxi_aw_size             = '0;
        masterAxi_aw_burst            = '0;
        masterAxi_w_valid             = 1'b0;
        masterAxi_w_data              = '0;
        masterAxi_w_strb              = '0;
        masterAxi_w_last              = 1'b0;
        masterAxi_b_ready             = 1'b0;
        masterAxi_ar_valid            = 1'b0;
        masterAxi_ar_addr             = '0;
        masterAxi_ar_id               = '0;
        masterAxi_ar_len              = '0;
        masterAxi_ar_size             = '0;
        masterAxi_ar_burst            = '0;
        masterAxi_r_ready             = 1'b0;

        case (state_q)
            S_IDLE: begin
                tcpBus_cmd_ready = 1'b1;
                if (tcpBus_cmd_valid) begin
                    addr_d      = tcpBus_addr & ~32'(BYTES - 1);
                    remaining_d = tcpBus_size;
                    resp_d      = 2'b00;
                    beat_cnt_d  = '0;
                    if (tcpBus_size == '0)     state_d = S_RSP;
                    else if (tcpBus_cmd_write) state_d = S_AW;
                    else                       state_d = S_AR;
                end
            end
            S_AW: begin
                masterAxi_aw_valid = 1'b1;
                masterAxi_aw_addr  = addr_q;
                masterAxi_aw_len   = 8'(burst_beats - 9'd1);
                masterAxi_aw_size  = AXI_SIZE;
                masterAxi_aw_burst = 2'b01;
                if (masterAxi_aw_ready) state_d = S_W;
            end
            S_W: begin
                masterAxi_w_valid  = tcpBus_wdata_valid;
                masterAxi_w_data   = tcpBus_wdata_payload_fragment;
                masterAxi_w_strb   = '1;
                masterAxi_w_last   = (beat_cnt_q == burst_beats - 9'd1);
                tcpBus_wdata_ready = masterAxi_w_ready;
                if (tcpBus_wdata_valid && masterAxi_w_ready) begin
                    if (masterAxi_w_last) begin
                        beat_cnt_d = '0;
                        state_d    = S_B;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 9'd1;
                    end
                end
            end
            S_B: begin
                masterAxi_b_ready = 1'b1;
                if (masterAxi_b_valid) begin
                    // Only the first error sticks; later responses cannot overwrite it.
                    if (resp_q == 2'b00) resp_d = masterAxi_b_resp;
                    remaining_d = remaining_q - SIZE_WIDTH'(burst_beats);
                    addr_d      = addr_q + addr_step;
                    state_d     = final_burst ? S_RSP : S_AW;
                end
            end
            S_AR: begin
                masterAxi_ar_valid = 1'b1;
                masterAxi_ar_addr  = addr_q;
                masterAxi_ar_len   = 8'(burst_beats - 9'd1);
                masterAxi_ar_size  = AXI_SIZE;
                masterAxi_ar_burst = 2'b01;
                if (masterAxi_ar_ready) state_d = S_R;
            end
            S_R: begin
                tcpBus_rdata_valid            = masterAxi_r_valid;
                tcpBus_rdata_payload_fragment = masterAxi_r_data;
                tcpBus_rdata_payload_last     = masterAxi_r_last && final_burst;
                masterAxi_r_ready             = tcpBus_rdata_ready;
                if (masterAxi_r_valid && tcpBus_rdata_ready) begin
                    if (resp_q == 2'b00) resp_d = masterAxi_r_resp;
                    if (masterAxi_r_last) begin
                        remaining_d = remaining_q - SIZE_WIDTH'(burst_beats);
                        addr_d      = addr_q + addr_step;
                        state_d     = final_burst ? S_RSP : S_AR;
                    end
                end
            end
            S_RSP: begin
                tcpBus_rsp_valid   = 1'b1;
                tcpBus_rsp_payload = resp_q;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_tcpbus_axi4_burst_master.sv
// Scoreboard bench: stimulus pushes expected AW/AR/W/rdata/rsp items, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_tcpbus_axi4_burst_master;
    localparam int DW = 128;
    localparam int SW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           cmd_valid, cmd_ready, cmd_write;
    logic [31:0]    cmd_addr;
    logic [SW-1:0]  cmd_size;
    logic           wd_valid, wd_ready, wd_last;
    logic [DW-1:0]  wd_frag;
    logic           rd_valid, rd_ready, rd_last;
    logic [DW-1:0]  rd_frag;
    logic           rsp_valid;
    logic [1:0]     rsp_payload;
    logic           aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [31:0]    aw_addr, ar_addr;
    logic [3:0]     aw_id, ar_id;
    logic [7:0]     aw_len, ar_len;
    logic [2:0]     aw_size, ar_size;
    logic [1:0]     aw_burst, ar_burst, b_resp, r_resp;
    logic [DW-1:0]  w_data, r_data;
    logic [DW/8-1:0] w_strb;
    logic           ar_valid, ar_ready, r_valid, r_ready, r_last;

    tcpbus_axi4_burst_master #(.DATA_WIDTH(DW), .MAX_BURST(256), .SIZE_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .tcpBus_cmd_valid(cmd_valid), .tcpBus_cmd_ready(cmd_ready), .tcpBus_cmd_write(cmd_write),
        .tcpBus_addr(cmd_addr), .tcpBus_size(cmd_size),
        .tcpBus_wdata_valid(wd_valid), .tcpBus_wdata_ready(wd_ready),
        .tcpBus_wdata_payload_fragment(wd_frag), .tcpBus_wdata_payload_last(wd_last),
        .tcpBus_rdata_valid(rd_valid), .tcpBus_rdata_ready(rd_ready),
        .tcpBus_rdata_payload_fragment(rd_frag), .tcpBus_rdata_payload_last(rd_last),
        .tcpBus_rsp_valid(rsp_valid), .tcpBus_rsp_payload(rsp_payload),
        .masterAxi_aw_valid(aw_valid), .masterAxi_aw_ready(aw_ready), .masterAxi_aw_addr(aw_addr),
        .masterAxi_aw_id(aw_id), .masterAxi_aw_len(aw_len), .masterAxi_aw_size(aw_size),
        .masterAxi_aw_burst(aw_burst),
        .masterAxi_w_valid(w_valid), .masterAxi_w_ready(w_ready), .masterAxi_w_data(w_data),
        .masterAxi_w_strb(w_strb), .masterAxi_w_last(w_last),
        .masterAxi_b_valid(b_valid), .masterAxi_b_ready(b_ready), .masterAxi_b_resp(b_resp),
        .masterAxi_ar_valid(ar_valid), .masterAxi_ar_ready(ar_ready), .masterAxi_ar_addr(ar_addr),
        .masterAxi_ar_id(ar_id), .masterAxi_ar_len(ar_len), .masterAxi_ar_size(ar_size),
        .masterAxi_ar_burst(ar_burst),
        .masterAxi_r_valid(r_valid), .masterAxi_r_ready(r_ready), .masterAxi_r_data(r_data),
        .masterAxi_r_resp(r_resp), .masterAxi_r_last(r_last)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rsp_count = 0;

    logic [39:0]  exp_aw[$];
    logic [39:0]  exp_ar[$];
    logic [128:0] exp_w[$];
    logic [128:0] exp_rd[$];
    logic [1:0]   exp_rsp[$];
    logic [1:0]   b_resp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event expected none/timely", name);
    endtask

    function automatic logic [127:0] wpat(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'(i), ~32'(i), 32'h1234_5678 ^ 32'(i)};
    endfunction

    function automatic logic [127:0] rpat(input logic [31:0] a);
        return {a ^ 32'hA5A5_A5A5, ~a, 32'hBEEF_0000, a};
    endfunction

    // Monitor: every DUT-presented handshake is checked against the scoreboard.
    logic [39:0]  m_e;
    logic [128:0] m_d;
    logic         rsp_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (aw_valid && aw_ready) begin
                if (exp_aw.size() == 0) fail_now("aw_unexpected");
                else begin
                    m_e = exp_aw.pop_front();
                    $display("AW  addr=%h len=%0d", aw_addr, aw_len);
                    chk("aw_addr", aw_addr, m_e[39:8]);
                    chk("aw_len", aw_len, m_e[7:0]);
                    chk("aw_size", aw_size, 3'd4);
                    chk("aw_burst", aw_burst, 2'b01);
                end
            end
            if (ar_valid && ar_ready) begin
                if (exp_ar.size() == 0) fail_now("ar_unexpected");
                else begin
                    m_e = exp_ar.pop_front();
                    $display("AR  addr=%h len=%0d", ar_addr, ar_len);
                    chk("ar_addr", ar_addr, m_e[39:8]);
                    chk("ar_len", ar_len, m_e[7:0]);
                    chk("ar_size", ar_size, 3'd4);
                end
            end
            if (w_valid && w_ready) begin
                if (exp_w.size() == 0) fail_now("w_unexpected");
                else begin
                    m_d = exp_w.pop_front();
                    chk("w_data", w_data, m_d[127:0]);
                    chk("w_last", w_last, m_d[128]);
                    chk("w_strb", w_strb, 16'hFFFF);
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) fail_now("rdata_unexpected");
                else begin
                    m_d = exp_rd.pop_front();
                    chk("rdata", rd_frag, m_d[127:0]);
                    chk("rdata_last", rd_last, m_d[128]);
                end
            end
            if (rsp_valid) begin
                rsp_count++;
                $display("RSP payload=%b", rsp_payload);
                if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
                else chk("rsp_payload", rsp_payload, exp_rsp.pop_front());
                if (rsp_prev) fail_now("rsp_pulse_width");
            end
            rsp_prev = rsp_valid;
        end else begin
            rsp_prev = 1'b0;
        end
    end

    // AXI slave model: always-ready address/W channels, queued B responses, R data = rpat(beat address).
    logic        s_rst, s_wl_hs, s_b_hs, s_ar_hs, s_r_hs, s_r_active;
    logic [31:0] s_ar_addr, s_r_base;
    logic [7:0]  s_ar_len, s_r_len, s_r_cnt;
    initial begin
        aw_ready = 1'b1; ar_ready = 1'b1; w_ready = 1'b1;
        b_valid = 1'b0; b_resp = 2'b00;
        r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
        s_r_active = 1'b0; s_r_base = '0; s_r_len = '0; s_r_cnt = '0;
        forever begin
            @(negedge clk);
            s_rst     = reset;
            s_wl_hs   = w_valid && w_ready && w_last;
            s_b_hs    = b_valid && b_ready;
            s_ar_hs   = ar_valid && ar_ready;
            s_ar_addr = ar_addr;
            s_ar_len  = ar_len;
            s_r_hs    = r_valid && r_ready;
            @(posedge clk);
            #1;
            if (s_rst) begin
                b_valid    = 1'b0;
                s_r_active = 1'b0;
            end else begin
                if (s_wl_hs) begin
                    b_valid = 1'b1;
                    b_resp  = (b_resp_q.size() != 0) ? b_resp_q.pop_front() : 2'b00;
                end else if (s_b_hs) begin
                    b_valid = 1'b0;
                end
                if (s_ar_hs) begin
                    s_r_active = 1'b1;
                    s_r_base   = s_ar_addr;
                    s_r_len    = s_ar_len;
                    s_r_cnt    = '0;
                end else if (s_r_hs) begin
                    if (s_r_cnt == s_r_len) s_r_active = 1'b0;
                    else s_r_cnt = s_r_cnt + 8'd1;
                end
            end
            r_valid = s_r_active;
            r_last  = s_r_active && (s_r_cnt == s_r_len);
            r_data  = s_r_active ? rpat(s_r_base + 32'(s_r_cnt) * 32'd16) : '0;
        end
    end

    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [SW-1:0] sz);
        int g;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!cmd_ready && g < 1000);
        if (g >= 1000) fail_now("cmd_ready_timeout");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        $display("CMD wr=%0d addr=%h size=%0d", wr, a, sz);
        @(negedge clk);
        if (sz == 0) begin
            chk("size0_rsp_next_cycle", rsp_valid, 1'b1);
            chk("size0_no_aw", aw_valid, 1'b0);
            chk("size0_no_ar", ar_valid, 1'b0);
        end else if (wr) chk("aw_valid_n_plus_1", aw_valid, 1'b1);
        else chk("ar_valid_n_plus_1", ar_valid, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_wdata(input int n, input int base);
        int g;
        for (int i = 0; i < n; i++) begin
            wd_valid = 1'b1;
            wd_frag  = wpat(base + i);
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!wd_ready && g < 2000);
            if (g >= 2000) fail_now("wdata_ready_timeout");
            @(posedge clk);
            #1;
        end
        wd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int g;
        g = 0;
        while (rsp_count < target && g < 5000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (rsp_count < target) fail_now("rsp_timeout");
        @(negedge clk);
        chk("cmd_ready_after_rsp", cmd_ready, 1'b1);
        chk("rsp_single_cycle", rsp_valid, 1'b0);
        chk("aw_left", 32'(exp_aw.size()), 32'd0);
        chk("ar_left", 32'(exp_ar.size()), 32'd0);
        chk("w_left", 32'(exp_w.size()), 32'd0);
        chk("rd_left", 32'(exp_rd.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input int n, input int base, input int last_a, input int last_b);
        for (int i = 0; i < n; i++) begin
            exp_w.push_back({(i == last_a) || (i == last_b), wpat(base + i)});
        end
    endtask

    task automatic push_rd(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back({i == n - 1, rpat(a + 32'(i) * 32'd16)});
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
        wd_valid = 1'b0; wd_frag = '0; wd_last = 1'b0; rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_aw_valid", aw_valid, 1'b0);
        chk("rst_ar_valid", ar_valid, 1'b0);
        chk("rst_w_valid", w_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rdata_valid", rd_valid, 1'b0);
        @(posedge clk);
        #1;

        // Single 4-beat write burst.
        exp_aw.push_back({32'h0000_1000, 8'd3});
        push_w(4, 0, 3, -1);
        b_resp_q.push_back(2'b00);
        exp_rsp.push_back(2'b00);
        do_cmd(1'b1, 32'h0000_1000, 20'd4);
        send_wdata(4, 0);
        wait_rsp(1);

        // Read straddling 0x1000.
`ifdef TCPBUS_AXI4_4K_SPLIT_EN
        exp_ar.push_back({32'h0000_0FE0, 8'd1});
        exp_ar.push_back({32'h0000_1000, 8'd1});
`else
        exp_ar.push_back({32'h0000_0FE0, 8'd3});
`endif
        push_rd(32'h0000_0FE0, 4);
        exp_rsp.push_back(2'b00);
        do_cmd(1'b0, 32'h0000_0FE0, 20'd4);
        wait_rsp(2);

        // 300-beat write: 256 + 44.
        exp_aw.push_back({32'h0000_0000, 8'd255});
        exp_aw.push_back({32'h0000_1000, 8'd43});
        push_w(300, 100, 255, 299);
        b_resp_q.push_back(2'b00);
        b_resp_q.push_back(2'b00);
        exp_rsp.push_back(2'b00);
        do_cmd(1'b1, 32'h0000_0000, 20'd300);
        send_wdata(300, 100);
        wait_rsp(3);

        // Two-burst write, first B SLVERR, second OKAY: error must stick.
        exp_aw.push_back({32'h0000_4000, 8'd255});
        exp_aw.push_back({32'h0000_5000, 8'd3});
        push_w(260, 500, 255, 259);
        b_resp_q.push_back(2'b10);
        b_resp_q.push_back(2'b00);
        exp_rsp.push_back(2'b10);
        do_cmd(1'b1, 32'h0000_4000, 20'd260);
        send_wdata(260, 500);
        wait_rsp(4);

        // Zero-size commands.
        exp_rsp.push_back(2'b00);
        do_cmd(1'b0, 32'h0000_8000, 20'd0);
        wait_rsp(5);
        exp_rsp.push_back(2'b00);
        do_cmd(1'b1, 32'h0000_9000, 20'd0);
        wait_rsp(6);

        // Unaligned address is forced down to the beat boundary.
        exp_ar.push_back({32'h0007_0FF0, 8'd0});
        push_rd(32'h0007_0FF0, 1);
        exp_rsp.push_back(2'b00);
        do_cmd(1'b0, 32'h0007_0FFF, 20'd1);
        wait_rsp(7);

        // Reset during a write after two of four beats.
        exp_aw.push_back({32'h0000_2000, 8'd3});
        push_w(2, 900, -1, -1);
        do_cmd(1'b1, 32'h0000_2000, 20'd4);
        send_wdata(2, 900);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_aw_valid", aw_valid, 1'b0);
        chk("midrst_w_valid", w_valid, 1'b0);
        chk("midrst_ar_valid", ar_valid, 1'b0);
        chk("midrst_b_ready", b_ready, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_w_left", 32'(exp_w.size()), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // One-beat read after the abandoned write.
        exp_ar.push_back({32'h0000_3000, 8'd0});
        push_rd(32'h0000_3000, 1);
        exp_rsp.push_back(2'b00);
        do_cmd(1'b0, 32'h0000_3000, 20'd1);
        wait_rsp(8);

        chk("rsp_total", 32'(rsp_count), 32'd8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
